bullcow_display: RTL and testbench

//  Renders the Bulls & Cows game outputs on the board's 8-digit multiplexed 7-segment display.

---
 rtl/bullcow_display.sv | 254 +++++++++++++++++++++++++
 tb/tb_bullcow_display.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bullcow_display.sv
// Bulls & Cows 8-digit multiplexed 7-segment driver: entry, result-hold and score views.
// Optional score blink is enabled by defining BULLCOW_DISP_BLINK_EN.
module bullcow_display #(
  parameter int REFRESH_DIV = 100_000,
  parameter int HOLD_CYCLES = 200_000_000,
  parameter int BLINK_DIV   = 50_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  game_state,
  input  logic        guess_confirmed,
  input  logic [2:0]  bull_count,
  input  logic [2:0]  cow_count,
  input  logic [7:0]  J1_points,
  input  logic [7:0]  J2_points,
  input  logic [15:0] SW,
  output logic [7:0]  an,
  output logic [7:0]  dec_cat
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST    = HW'(HOLD_CYCLES - 1);

  // Symbol codes: 0..15 are hex digits, the rest are glyphs
  localparam logic [4:0] SYM_J     = 5'd16;
  localparam logic [4:0] SYM_B     = 5'd17;
  localparam logic [4:0] SYM_C     = 5'd18;
  localparam logic [4:0] SYM_DASH  = 5'd19;
  localparam logic [4:0] SYM_BLANK = 5'd20;
  localparam logic [2:0] GS_END    = 3'b111;

  typedef enum logic [1:0] {
    MODE_ENTRY  = 2'd0,
    MODE_RESULT = 2'd1,
    MODE_SCORE  = 2'd2
  } mode_t;

  mode_t           mode_r;
  mode_t           mode_nxt_s;
  logic [RW-1:0]   refresh_cnt_r;
  logic [2:0]      digit_idx_r;
  logic [HW-1:0]   hold_cnt_r;
  logic [HW-1:0]   hold_nxt_s;
  logic [2:0]      b_lat_r;
  logic [2:0]      c_lat_r;
  logic [2:0]      b_nxt_s;
  logic [2:0]      c_nxt_s;
  logic            prev_gc_r;
  logic            gc_rise_s;
  logic            blank_s;
  logic            entry_view_s;
  logic [4:0]      player_sym_s;
  logic [4:0]      sym_s;
  logic [7:0]      an_nxt_s;
  logic [7:0]      an_r;
  logic [7:0]      dec_cat_r;

  function automatic logic [7:0] seg_encode(input logic [4:0] sym);
    logic [7:0] seg;
    case (sym)
      5'd0:    seg = 8'hC0;
      5'd1:    seg = 8'hF9;
      5'd2:    seg = 8'hA4;
      5'd3:    seg = 8'hB0;
      5'd4:    seg = 8'h99;
      5'd5:    seg = 8'h92;
      5'd6:    seg = 8'h82;
      5'd7:    seg = 8'hF8;
      5'd8:    seg = 8'h80;
      5'd9:    seg = 8'h90;
      5'd10:   seg = 8'h88;
      5'd11:   seg = 8'h83;
      5'd12:   seg = 8'hC6;
      5'd13:   seg = 8'hA1;
      5'd14:   seg = 8'h86;
      5'd15:   seg = 8'h8E;
      SYM_J:   seg = 8'hE1;
      SYM_B:   seg = 8'h83;
      SYM_C:   seg = 8'hA7;
      SYM_DASH: seg = 8'hBF;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

  // Switch nibbles beyond decimal range are not valid guess digits
  function automatic logic [4:0] entry_nibble(input logic [3:0] nib);
    logic [4:0] sym;
    if (nib > 4'd9) begin
      sym = SYM_DASH;
    end else begin
      sym = {1'b0, nib};
    end
    return sym;
  endfunction

  assign gc_rise_s = guess_confirmed & ~prev_gc_r;

  // Mode next-state, hold timer and result latches
  always_comb begin
    mode_nxt_s = mode_r;
    hold_nxt_s = hold_cnt_r;
    b_nxt_s    = b_lat_r;
    c_nxt_s    = c_lat_r;
    if (gc_rise_s) begin
      b_nxt_s = bull_count;
      c_nxt_s = cow_count;
    end else begin
      b_nxt_s = b_lat_r;
      c_nxt_s = c_lat_r;
    end
    if (game_state == GS_END) begin
      mode_nxt_s = MODE_SCORE;
      hold_nxt_s = {HW{1'b0}};
    end else begin
      case (mode_r)
        MODE_ENTRY: begin
          if (gc_rise_s) begin
            mode_nxt_s = MODE_RESULT;
            hold_nxt_s = {HW{1'b0}};
          end else begin
            mode_nxt_s = MODE_ENTRY;
          end
        end
        MODE_RESULT: begin
          if (gc_rise_s) begin
            hold_nxt_s = {HW{1'b0}};
          end else if (hold_cnt_r == HOLD_LAST) begin
            mode_nxt_s = MODE_ENTRY;
            hold_nxt_s = {HW{1'b0}};
          end else begin
            hold_nxt_s = hold_cnt_r + HW'(1);
          end
        end
        MODE_SCORE:  mode_nxt_s = MODE_ENTRY;
        default:     mode_nxt_s = MODE_ENTRY;
      endcase
    end
  end

  // Symbol for the digit currently being scanned
  always_comb begin
    sym_s        = SYM_BLANK;
    player_sym_s = SYM_DASH;
    entry_view_s = (mode_r == MODE_ENTRY) || (game_state[2] && (game_state != GS_END));
    case (game_state)
      3'b000, 3'b010: player_sym_s = 5'd1;
      3'b001, 3'b011: player_sym_s = 5'd2;
      default:        player_sym_s = SYM_DASH;
    endcase
    if (entry_view_s) begin
      case (digit_idx_r)
        3'd7:    sym_s = SYM_J;
        3'd6:    sym_s = player_sym_s;
        3'd3:    sym_s = entry_nibble(SW[15:12]);
        3'd2:    sym_s = entry_nibble(SW[11:8]);
        3'd1:    sym_s = entry_nibble(SW[7:4]);
        3'd0:    sym_s = entry_nibble(SW[3:0]);
        default: sym_s = SYM_BLANK;
      endcase
    end else if (mode_r == MODE_RESULT) begin
      case (digit_idx_r)
        3'd7:    sym_s = {2'b00, b_lat_r};
        3'd6:    sym_s = SYM_B;
        3'd3:    sym_s = {2'b00, c_lat_r};
        3'd2:    sym_s = SYM_C;
        default: sym_s = SYM_BLANK;
      endcase
    end else begin
      case (digit_idx_r)
        3'd7:    sym_s = {1'b0, J1_points[7:4]};
        3'd6:    sym_s = {1'b0, J1_points[3:0]};
        3'd4:    sym_s = SYM_DASH;
        3'd3:    sym_s = SYM_DASH;
        3'd1:    sym_s = {1'b0, J2_points[7:4]};
        3'd0:    sym_s = {1'b0, J2_points[3:0]};
        default: sym_s = SYM_BLANK;
      endcase
    end
  end

  // Anode pattern, optionally blanked during the score blink
  always_comb begin
    an_nxt_s = 8'hFF;
    if (blank_s) begin
      an_nxt_s = 8'hFF;
    end else begin
      an_nxt_s = ~(8'b0000_0001 << digit_idx_r);
    end
  end

`ifdef BULLCOW_DISP_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  logic [BW-1:0] blink_cnt_r;
  logic          blink_r;

  // Blink timebase; held clear outside SCORE so every score entry starts unblanked
  always_ff @(posedge clock) begin
    if (reset) begin
      blink_cnt_r <= {BW{1'b0}};
      blink_r     <= 1'b0;
    end else if (mode_r != MODE_SCORE) begin
      blink_cnt_r <= {BW{1'b0}};
      blink_r     <= 1'b0;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r <= {BW{1'b0}};
      blink_r     <= ~blink_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BW'(1);
    end
  end

  assign blank_s = (mode_r == MODE_SCORE) && blink_r;
`else
  localparam int blink_div_unused = BLINK_DIV;
  assign blank_s = 1'b0;
`endif

  // Scan timebase, mode state, latches and registered pin outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      refresh_cnt_r <= {RW{1'b0}};
      digit_idx_r   <= 3'd0;
      mode_r        <= MODE_ENTRY;
      hold_cnt_r    <= {HW{1'b0}};
      b_lat_r       <= 3'd0;
      c_lat_r       <= 3'd0;
      prev_gc_r     <= 1'b0;
      an_r          <= 8'hFF;
      dec_cat_r     <= 8'hFF;
    end else begin
      prev_gc_r <= guess_confirmed;
      if (refresh_cnt_r == REFRESH_LAST) begin
        refresh_cnt_r <= {RW{1'b0}};
        digit_idx_r   <= digit_idx_r + 3'd1;
      end else begin
        refresh_cnt_r <= refresh_cnt_r + RW'(1);
      end
      mode_r     <= mode_nxt_s;
      hold_cnt_r <= hold_nxt_s;
      b_lat_r    <= b_nxt_s;
      c_lat_r    <= c_nxt_s;
      an_r       <= an_nxt_s;
      dec_cat_r  <= seg_encode(sym_s);
    end
  end

  assign an      = an_r;
  assign dec_cat = dec_cat_r;

endmodule

// File: tb/tb_bullcow_display.sv
// Scoreboard bench for bullcow_display: tasks push expected views, a negedge monitor pops and compares.
module tb_bullcow_display;

  localparam int RD = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  game_state = 3'b000;
  logic        guess_confirmed = 1'b0;
  logic [2:0]  bull_count = 3'd0;
  logic [2:0]  cow_count = 3'd0;
  logic [7:0]  J1_points = 8'h00;
  logic [7:0]  J2_points = 8'h00;
  logic [15:0] SW = 16'h0000;
  logic [7:0]  an;
  logic [7:0]  dec_cat;

  int checks = 0;
  int passes = 0;
  int blanks = 0;

  typedef struct {
    string       name;
    logic [63:0] view;
    logic [7:0]  an_exp;
    bit          an_chk;
    bit          allow_blank;
    bit          skip;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   mon_d;

  bullcow_display #(.REFRESH_DIV(4), .HOLD_CYCLES(20), .BLINK_DIV(8)) dut (
    .clock(clock), .reset(reset), .game_state(game_state),
    .guess_confirmed(guess_confirmed), .bull_count(bull_count), .cow_count(cow_count),
    .J1_points(J1_points), .J2_points(J2_points), .SW(SW), .an(an), .dec_cat(dec_cat)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    logic [7:0] tbl [16];
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return tbl[n];
  endfunction

  function automatic logic [7:0] ent_seg(input logic [3:0] n);
    return (n > 4'd9) ? 8'hBF : hex_seg(n);
  endfunction

  function automatic logic [63:0] entry_view(input logic [7:0] player, input logic [15:0] sw);
    return {8'hE1, player, 8'hFF, 8'hFF,
            ent_seg(sw[15:12]), ent_seg(sw[11:8]), ent_seg(sw[7:4]), ent_seg(sw[3:0])};
  endfunction

  function automatic logic [63:0] result_view(input logic [2:0] b, input logic [2:0] c);
    return {hex_seg({1'b0, b}), 8'h83, 8'hFF, 8'hFF, hex_seg({1'b0, c}), 8'hA7, 8'hFF, 8'hFF};
  endfunction

  function automatic logic [63:0] score_view(input logic [7:0] j1, input logic [7:0] j2);
    return {hex_seg(j1[7:4]), hex_seg(j1[3:0]), 8'hFF, 8'hBF, 8'hBF, 8'hFF,
            hex_seg(j2[7:4]), hex_seg(j2[3:0])};
  endfunction

  // Queue `skip` unchecked cycles then n expected samples, starting at the next falling edge
  task automatic push_samples(input string name, input logic [63:0] view, input int skip,
                              input int n, input bit an_chk, input bit allow_blank);
    exp_t e;
    #1;
    for (int i = 0; i < skip + n; i++) begin
      e.name        = name;
      e.view        = view;
      e.skip        = (i < skip);
      e.an_chk      = an_chk;
      e.an_exp      = ~(8'd1 << (((i - skip) / RD) % 8));
      e.allow_blank = allow_blank;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      #1;
      if (sb_q.size() == 0) break;
    end
    if (sb_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d samples left, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Scoreboard consumer: one expected sample per falling edge
  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      if (!mon_e.skip) begin
        if (mon_e.an_chk) begin
          checks++;
          if (an !== mon_e.an_exp)
            $display("FAIL %s_an: an=%h required %h", mon_e.name, an, mon_e.an_exp);
          else
            passes++;
        end
        if (an === 8'hFF && mon_e.allow_blank) begin
          blanks++;
        end else begin
          checks++;
          mon_d = -1;
          for (int k = 0; k < 8; k++) if (an[k] === 1'b0) mon_d = k;
          if ($countones(~an) != 1 || mon_d < 0)
            $display("FAIL %s_onehot: an=%h required a single low anode", mon_e.name, an);
          else if (dec_cat !== mon_e.view[mon_d*8 +: 8])
            $display("FAIL %s_digit%0d: dec_cat=%h required %h", mon_e.name, mon_d, dec_cat,
                     mon_e.view[mon_d*8 +: 8]);
          else
            passes++;
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; game_state = 3'b000; SW = 16'h1234; guess_confirmed = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (an !== 8'hFF) $display("FAIL reset_an: an=%h required ff", an); else passes++;
    checks++;
    if (dec_cat !== 8'hFF) $display("FAIL reset_cat: dec_cat=%h required ff", dec_cat); else passes++;
    reset = 1'b0;
    push_samples("entry_scan", entry_view(8'hF9, 16'h1234), 0, 32, 1'b1, 1'b0);
    wait_drain();
  endtask

  task automatic test_result();
    logic [7:0] prev;
    bit found;
    @(negedge clock);
    game_state = 3'b010; bull_count = 3'd2; cow_count = 3'd1;
    prev = an; found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clock);
      if (an === 8'h7F && prev !== 8'h7F) found = 1'b1;
      prev = an;
    end
    checks++;
    if (!found) $display("FAIL result_align: digit 7 slot not seen, an=%h", an); else passes++;
    guess_confirmed = 1'b1;
    push_samples("result", result_view(3'd2, 3'd1), 1, 20, 1'b0, 1'b0);
    push_samples("after_hold", entry_view(8'hF9, 16'h1234), 0, 20, 1'b0, 1'b0);
    wait_drain();
  endtask

  task automatic test_sw_dash();
    @(negedge clock);
    guess_confirmed = 1'b0; game_state = 3'b011; SW = 16'h1A23;
    push_samples("sw_dash", entry_view(8'hA4, 16'h1A23), 2, 32, 1'b0, 1'b0);
    wait_drain();
  endtask

  task automatic test_undefined_state();
    @(negedge clock);
    game_state = 3'b101;
    push_samples("undef_state", entry_view(8'hBF, 16'h1A23), 2, 32, 1'b0, 1'b0);
    wait_drain();
  endtask

  task automatic test_score();
    @(negedge clock);
    game_state = 3'b111; J1_points = 8'h0C; J2_points = 8'h03;
    blanks = 0;
`ifdef BULLCOW_DISP_BLINK_EN
    push_samples("score", score_view(8'h0C, 8'h03), 2, 32, 1'b0, 1'b1);
    wait_drain();
    checks++;
    if (blanks != 16) $display("FAIL score_blink: blanked=%0d required 16", blanks); else passes++;
`else
    push_samples("score", score_view(8'h0C, 8'h03), 2, 32, 1'b0, 1'b0);
    wait_drain();
    checks++;
    if (blanks != 0) $display("FAIL score_steady: blanked=%0d required 0", blanks); else passes++;
`endif
  endtask

  task automatic test_gc_with_end();
    @(negedge clock);
    game_state = 3'b000;
    repeat (3) @(negedge clock);
    game_state = 3'b111; guess_confirmed = 1'b1; bull_count = 3'd3; cow_count = 3'd4;
    push_samples("gc_end_score", score_view(8'h0C, 8'h03), 1, 8, 1'b0, 1'b1);
    wait_drain();
    checks++;
    if (dut.b_lat_r !== 3'd3) $display("FAIL gc_end_blat: b_lat=%0d required 3", dut.b_lat_r);
    else passes++;
    checks++;
    if (dut.c_lat_r !== 3'd4) $display("FAIL gc_end_clat: c_lat=%0d required 4", dut.c_lat_r);
    else passes++;
    @(negedge clock);
    game_state = 3'b000;
    push_samples("score_exit_lag", score_view(8'h0C, 8'h03), 0, 1, 1'b0, 1'b1);
    push_samples("score_exit", entry_view(8'hF9, 16'h1A23), 0, 8, 1'b0, 1'b0);
    wait_drain();
  endtask

  task automatic test_reset_mid_result();
    @(negedge clock);
    guess_confirmed = 1'b0;
    @(negedge clock);
    guess_confirmed = 1'b1; bull_count = 3'd4; cow_count = 3'd0;
    push_samples("pre_reset_result", result_view(3'd4, 3'd0), 1, 4, 1'b0, 1'b0);
    wait_drain();
    @(negedge clock);
    reset = 1'b1; guess_confirmed = 1'b0;
    @(negedge clock);
    checks++;
    if (an !== 8'hFF) $display("FAIL midreset_an: an=%h required ff", an); else passes++;
    checks++;
    if (dec_cat !== 8'hFF) $display("FAIL midreset_cat: dec_cat=%h required ff", dec_cat); else passes++;
    reset = 1'b0;
    push_samples("post_reset", entry_view(8'hF9, 16'h1A23), 0, 32, 1'b1, 1'b0);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_result();
    test_sw_dash();
    test_undefined_state();
    test_score();
    test_gc_with_end();
    test_reset_mid_result();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
